// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO between the UART receiver and the CPU MMIO read path.
// Define UART_RX_FIFO_DROP_EN to discard overflow bytes instead of stalling the receiver.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic [7:0]    drop_count
);

   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;
   logic          push;
   logic          pop;

   assign full      = (occ == DEPTH_C);
   assign empty     = (occ == '0);
   assign out_valid = ~empty;
   assign count     = occ;
   assign out_data  = mem[rd_ptr];
   assign pop       = out_valid & out_ready;

`ifdef UART_RX_FIFO_DROP_EN
   logic [7:0] drop_cnt;

   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign in_ready   = 1'b1;
   assign push       = in_valid & (~full | pop);
   assign drop_count = drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= 8'd0;
      end else if (in_valid && full && !pop && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`else
   assign in_ready   = ~full;
   assign push       = in_valid & ~full;
   assign drop_count = 8'd0;
`endif

   // Storage carries no reset; stale entries are hidden by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   occ <= occ + CNT_ONE;
            2'b01:   occ <= occ - CNT_ONE;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, 2..256).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, 8, received byte from the UART receiver (DataOut).
REQ-006 SHALL have port in_valid, input, 1, received byte present (DataOutValid).
REQ-007 SHALL have port in_ready, output, 1, FIFO accepts byte this cycle (drives DataOutReady).
REQ-008 SHALL have port out_data, output, 8, head byte toward the CPU MMIO read path.
REQ-009 SHALL have port out_valid, output, 1, head byte valid; equals ~empty.
REQ-010 SHALL have port out_ready, input, 1, CPU pops the head byte this cycle.
REQ-011 SHALL have port count, output, AW+1, current occupancy 0..DEPTH.
REQ-012 SHALL have ports full and empty, output, 1 each, occupancy == DEPTH and occupancy == 0.
REQ-013 SHALL have port drop_count, output, 8, bytes discarded while full.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; byte written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-015 Pop SHALL occur when out_valid && out_ready; rd_ptr increments modulo DEPTH.
REQ-016 out_data SHALL be show-ahead: it equals mem[rd_ptr] whenever out_valid=1, with no read latency.
REQ-017 Push-to-out_valid latency SHALL be exactly 1 cycle; an empty FIFO SHALL never pass in_data combinationally to out_data.
REQ-018 count SHALL be registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 full, empty and out_valid SHALL be derived only from registered count; in_ready SHALL NOT depend combinationally on out_ready.
REQ-020 A pop when empty SHALL be impossible (out_valid=0); out_ready when empty SHALL have no effect.
REQ-021 A simultaneous push and pop at count 1..DEPTH-1 SHALL both complete in the same cycle.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated byte; order SHALL be strictly FIFO.
REQ-023 Storage SHALL be a register array; contents are not reset and are unobservable while empty.

Reset
REQ-024 While rst=1: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, drop_count=0, in_ready=1.
REQ-025 rst asserted mid-operation SHALL discard all queued bytes immediately (asynchronous), without waiting for a clock edge.
REQ-026 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro UART_RX_FIFO_DROP_EN SHALL select the overflow policy.
REQ-028 With UART_RX_FIFO_DROP_EN defined: in_ready SHALL be constant 1, so the UART never stalls.
REQ-029 With UART_RX_FIFO_DROP_EN defined: a byte with in_valid=1 while full and no pop SHALL be discarded; drop_count SHALL increment, saturating at 255.
REQ-030 With UART_RX_FIFO_DROP_EN defined: a byte with in_valid=1 while full and a pop in the same cycle SHALL be accepted, not dropped.
REQ-031 Without UART_RX_FIFO_DROP_EN: in_ready SHALL equal ~full, the UART holds the byte (backpressure), and drop_count SHALL be constant 0.

Verification
REQ-032 Single byte (DEPTH=8): push 8'h7a into empty -> out_valid=1 and out_data=8'h7a the next cycle, count=1; pop -> empty=1 the next cycle.
REQ-033 Fill/wrap: push 8'h00..8'h07 (full=1, in_ready=0 without the macro), pop 3, push 8'h08..8'h0A -> pops read 8'h03..8'h0A in order.
REQ-034 Simultaneous push and pop at count=4 for 20 cycles -> count stays 4 and output sequence is the input sequence delayed by 4 entries.
REQ-035 Drop mode (macro defined): with full, push 300 bytes with no pop -> drop_count=255, FIFO contents unchanged; push while popping when full -> byte accepted, drop_count unchanged.
REQ-036 Reset mid-stream: rst pulse between clock edges at count=5 -> count=0, empty=1 and out_valid=0 before the next edge; next push 8'h80 reads back as 8'h80.
